div_ctrl: RTL and testbench

//  EX-stage sequencer for the 32-bit iterative divider. Accepts DIV/DIVU from EX, latches operands, holds the

---
 rtl/div_ctrl_if.sv | 30 +++
 rtl/div_ctrl.sv | 164 ++++++++++++++++
 tb/tb_div_ctrl.sv | 326 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/div_ctrl_if.sv
// Divider-side bus of the EX-stage divide sequencer.
//   master : sequencer side (drives operands, level start, annul; receives result/ready)
//   slave  : iterative divider side
// Signals:
//   div_signed_o  1   signed_div_i of the divider (1 = DIV, 0 = DIVU)
//   div_op1_o     32  dividend
//   div_op2_o     32  divisor
//   div_start_o   1   level start, held high for the whole operation
//   div_annul_o   1   one-cycle abort request
//   div_result_i  64  {remainder, quotient}
//   div_ready_i   1   result valid
interface div_ctrl_if;
  logic        div_signed_o;
  logic [31:0] div_op1_o;
  logic [31:0] div_op2_o;
  logic        div_start_o;
  logic        div_annul_o;
  logic [63:0] div_result_i;
  logic        div_ready_i;

  modport master (
    output div_signed_o, div_op1_o, div_op2_o, div_start_o, div_annul_o,
    input  div_result_i, div_ready_i
  );

  modport slave (
    input  div_signed_o, div_op1_o, div_op2_o, div_start_o, div_annul_o,
    output div_result_i, div_ready_i
  );
endinterface

// File: rtl/div_ctrl.sv
// EX-stage sequencer for the 32-bit iterative divider.
// Accepts DIV/DIVU from EX, latches the operands, holds the divider's level
// start, stalls IF..EX until the result is ready and then writes {HI,LO}.
// A pipeline flush or the watchdog aborts the operation and drains the
// divider back to its free state.
// Ports:
//   clk, rst       clock, synchronous active-high reset
//   ex_div_valid   divide present in EX (held while stall_o = 1)
//   ex_div_signed  1 = DIV, 0 = DIVU
//   ex_op_a/b      dividend / divisor
//   flush          kill the EX instruction
//   stall_o        freeze IF..EX (combinational)
//   div            divider bus (master side)
//   hilo_we        one-cycle HI/LO write strobe
//   hi_o / lo_o    remainder / quotient
//   timeout_o      one-cycle pulse on watchdog abort
module div_ctrl #(
  parameter int unsigned TIMEOUT_CYCLES = 48,
  parameter int unsigned DRAIN_CYCLES   = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ex_div_valid,
  input  logic              ex_div_signed,
  input  logic [31:0]       ex_op_a,
  input  logic [31:0]       ex_op_b,
  input  logic              flush,
  output logic              stall_o,
  div_ctrl_if.master        div,
  output logic              hilo_we,
  output logic [31:0]       hi_o,
  output logic [31:0]       lo_o,
  output logic              timeout_o
);

  localparam int unsigned CNT_MAX = (TIMEOUT_CYCLES > DRAIN_CYCLES) ? TIMEOUT_CYCLES : DRAIN_CYCLES;
  localparam int unsigned CW      = $clog2(CNT_MAX + 1);

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE,
    DRAIN
  } state_e;

  state_e      state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic        signed_q, signed_d;
  logic [31:0] op1_q, op1_d;
  logic [31:0] op2_q, op2_d;
  logic        start_q, start_d;
  logic        annul_q, annul_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;
  logic        timeout_q, timeout_d;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    signed_d  = signed_q;
    op1_d     = op1_q;
    op2_d     = op2_q;
    start_d   = start_q;
    annul_d   = 1'b0;
    hi_d      = hi_q;
    lo_d      = lo_q;
    timeout_d = 1'b0;
    stall_o   = 1'b0;
    hilo_we   = 1'b0;

    case (state_q)
      IDLE: begin
        stall_o = ex_div_valid & ~flush;
        if (ex_div_valid && !flush) begin
          signed_d = ex_div_signed;
          op1_d    = ex_op_a;
          op2_d    = ex_op_b;
          start_d  = 1'b1;
          cnt_d    = '0;
          state_d  = BUSY;
        end
      end

      BUSY: begin
        // Operands stay frozen: the divider re-reads them at sign fix-up.
        stall_o = 1'b1;
        if (flush) begin
          // Flush beats a coincident ready: the result is discarded.
          start_d = 1'b0;
          annul_d = 1'b1;
          cnt_d   = '0;
          state_d = DRAIN;
        end else if (div.div_ready_i) begin
          hi_d    = div.div_result_i[63:32];
          lo_d    = div.div_result_i[31:0];
          start_d = 1'b0;
          state_d = DONE;
        end else if (cnt_q == CW'(TIMEOUT_CYCLES - 1)) begin
          timeout_d = 1'b1;
          start_d   = 1'b0;
          annul_d   = 1'b1;
          cnt_d     = '0;
          state_d   = DRAIN;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      DONE: begin
        // The divide retires this cycle; a flush here kills the write.
        hilo_we = ~flush;
        state_d = IDLE;
      end

      DRAIN: begin
        stall_o = ex_div_valid;
        if (cnt_q == CW'(DRAIN_CYCLES - 1)) begin
          cnt_d   = '0;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      signed_q  <= 1'b0;
      op1_q     <= '0;
      op2_q     <= '0;
      start_q   <= 1'b0;
      annul_q   <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      signed_q  <= signed_d;
      op1_q     <= op1_d;
      op2_q     <= op2_d;
      start_q   <= start_d;
      annul_q   <= annul_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      timeout_q <= timeout_d;
    end
  end

  assign div.div_signed_o = signed_q;
  assign div.div_op1_o    = op1_q;
  assign div.div_op2_o    = op2_q;
  assign div.div_start_o  = start_q;
  assign div.div_annul_o  = annul_q;
  assign hi_o             = hi_q;
  assign lo_o             = lo_q;
  assign timeout_o        = timeout_q;

endmodule

// File: tb/tb_div_ctrl.sv
module tb_div_ctrl;

  localparam int STUB_LAT  = 32;  // busy countdown of the stub divider for nonzero divisors
  localparam int ZERO_LAT  = 2;   // countdown for divide-by-zero
  localparam int TIMEOUT   = 48;

  logic        clk;
  logic        rst;
  logic        ex_div_valid;
  logic        ex_div_signed;
  logic [31:0] ex_op_a;
  logic [31:0] ex_op_b;
  logic        flush;
  logic        stall_o;
  logic        hilo_we;
  logic [31:0] hi_o;
  logic [31:0] lo_o;
  logic        timeout_o;

  div_ctrl_if dv ();

  div_ctrl #(.TIMEOUT_CYCLES(TIMEOUT), .DRAIN_CYCLES(2)) dut (
    .clk           (clk),
    .rst           (rst),
    .ex_div_valid  (ex_div_valid),
    .ex_div_signed (ex_div_signed),
    .ex_op_a       (ex_op_a),
    .ex_op_b       (ex_op_b),
    .flush         (flush),
    .stall_o       (stall_o),
    .div           (dv.master),
    .hilo_we       (hilo_we),
    .hi_o          (hi_o),
    .lo_o          (lo_o),
    .timeout_o     (timeout_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int we_cnt = 0;
  int annul_cnt = 0;
  int to_cnt = 0;
  int overlap_cnt = 0;

  // Reference: MIPS DIV/DIVU semantics (truncating quotient, remainder takes
  // the dividend's sign), divide-by-zero yields all zeros.
  function automatic logic [63:0] ref_div(input logic sgn, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, q, r;
    if (b == 32'd0) return 64'd0;
    if (sgn) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
    end else begin
      sa = longint'({32'd0, a});
      sb = longint'({32'd0, b});
    end
    q = sa / sb;
    r = sa % sb;
    return {r[31:0], q[31:0]};
  endfunction

  // Stub iterative divider: level start, fixed latency, ready held until start drops.
  logic stub_never;
  int   stub_state;
  int   stub_cnt;
  logic [63:0] stub_res;

  always @(posedge clk) begin
    if (rst) begin
      stub_state      <= 0;
      stub_cnt        <= 0;
      stub_res        <= '0;
      dv.div_ready_i  <= 1'b0;
      dv.div_result_i <= '0;
    end else begin
      case (stub_state)
        0: begin
          dv.div_ready_i <= 1'b0;
          if (dv.div_start_o && !dv.div_annul_o) begin
            stub_res   <= ref_div(dv.div_signed_o, dv.div_op1_o, dv.div_op2_o);
            stub_cnt   <= (dv.div_op2_o == 32'd0) ? ZERO_LAT : STUB_LAT;
            stub_state <= 1;
          end
        end
        1: begin
          if (dv.div_annul_o) stub_state <= 0;
          else if (stub_cnt == 0) begin
            if (!stub_never) begin
              dv.div_ready_i  <= 1'b1;
              dv.div_result_i <= stub_res;
              stub_state      <= 2;
            end
          end else stub_cnt <= stub_cnt - 1;
        end
        default: begin
          if (!dv.div_start_o) begin
            dv.div_ready_i <= 1'b0;
            stub_state     <= 0;
          end
        end
      endcase
    end
  end

  always @(negedge clk) begin
    if (hilo_we === 1'b1) we_cnt++;
    if (dv.div_annul_o === 1'b1) annul_cnt++;
    if (timeout_o === 1'b1) to_cnt++;
    if (dv.div_annul_o === 1'b1 && dv.div_start_o === 1'b1) overlap_cnt++;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive point is 1 time unit after the rising edge; sample point 2.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run_div(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                         output int stall_n, output logic [31:0] hi_w, output logic [31:0] lo_w,
                         output logic stall_w, output logic got);
    ex_div_signed = sgn;
    ex_op_a       = a;
    ex_op_b       = b;
    ex_div_valid  = 1'b1;
    stall_n = 0;
    got     = 1'b0;
    hi_w    = '0;
    lo_w    = '0;
    stall_w = 1'b1;
    for (int i = 0; i < 200 && !got; i++) begin
      #1;
      if (hilo_we === 1'b1) begin
        got     = 1'b1;
        hi_w    = hi_o;
        lo_w    = lo_o;
        stall_w = stall_o;
      end else begin
        if (stall_o === 1'b1) stall_n++;
        @(posedge clk);
      end
    end
    step();
    ex_div_valid = 1'b0;
  endtask

  task automatic wait_ready(output logic got);
    got = 1'b0;
    for (int i = 0; i < 200 && !got; i++) begin
      #1;
      if (dv.div_ready_i === 1'b1) got = 1'b1;
      else @(posedge clk);
    end
  endtask

  int          sn;
  logic [31:0] hw, lw;
  logic        sw, got;
  int          we0, an0, to0;
  logic [63:0] exp_r;
  logic        rs;
  logic [31:0] ra, rb;

  initial begin
    rst = 1'b1; ex_div_valid = 1'b0; ex_div_signed = 1'b0;
    ex_op_a = '0; ex_op_b = '0; flush = 1'b0; stub_never = 1'b0;
    repeat (3) step();
    #1;
    chk("rst_start", 64'(dv.div_start_o), 64'd0);
    chk("rst_annul", 64'(dv.div_annul_o), 64'd0);
    chk("rst_hilo_we", 64'(hilo_we), 64'd0);
    chk("rst_timeout", 64'(timeout_o), 64'd0);
    chk("rst_hilo", {hi_o, lo_o}, 64'd0);
    chk("rst_ops", {dv.div_op1_o, dv.div_op2_o}, 64'd0);
    chk("rst_stall", 64'(stall_o), 64'd0);
    step();
    rst = 1'b0;
    step();

    // DIVU 100/7
    we0 = we_cnt;
    run_div(1'b0, 32'd100, 32'd7, sn, hw, lw, sw, got);
    chk("divu_100_7_done", 64'(got), 64'd1);
    chk("divu_100_7_hi", 64'(hw), 64'd2);
    chk("divu_100_7_lo", 64'(lw), 64'd14);
    chk("divu_100_7_stall_at_we", 64'(sw), 64'd0);
    chk("divu_100_7_stall_cycles", 64'(sn), 64'(STUB_LAT + 4));
    chk("divu_100_7_we_count", 64'(we_cnt - we0), 64'd1);

    // DIV -7/2 back-to-back
    run_div(1'b1, 32'hFFFF_FFF9, 32'd2, sn, hw, lw, sw, got);
    chk("div_m7_2_hi", 64'(hw), 64'hFFFF_FFFF);
    chk("div_m7_2_lo", 64'(lw), 64'hFFFF_FFFD);

    // DIV 0x80000000 / -1
    we0 = we_cnt;
    run_div(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, sn, hw, lw, sw, got);
    chk("div_ovf_done", 64'(got), 64'd1);
    chk("div_ovf_we_count", 64'(we_cnt - we0), 64'd1);
    chk("div_ovf_hilo", {hw, lw}, {32'd0, 32'h8000_0000});

    // DIV 5/0
    run_div(1'b1, 32'd5, 32'd0, sn, hw, lw, sw, got);
    chk("div0_done", 64'(got), 64'd1);
    chk("div0_fast", 64'(sn <= 6), 64'd1);
    chk("div0_hilo", {hw, lw}, 64'd0);

    // Flush at BUSY cycle 10
    we0 = we_cnt; an0 = annul_cnt;
    ex_div_signed = 1'b0; ex_op_a = 32'd1000; ex_op_b = 32'd3; ex_div_valid = 1'b1;
    repeat (11) step();
    flush = 1'b1;
    #1;
    chk("flush_busy_stall", 64'(stall_o), 64'd1);
    step();
    flush = 1'b0; ex_div_valid = 1'b0;
    #1;
    chk("flush_annul_start", {63'd0, dv.div_annul_o} << 1 | 64'(dv.div_start_o), 64'd2);
    step();
    #1;
    chk("flush_annul_one_cycle", 64'(dv.div_annul_o), 64'd0);
    step();
    chk("flush_no_we", 64'(we_cnt - we0), 64'd0);
    chk("flush_annul_count", 64'(annul_cnt - an0), 64'd1);
    run_div(1'b0, 32'd9, 32'd3, sn, hw, lw, sw, got);
    chk("after_flush_hilo", {hw, lw}, {32'd0, 32'd3});
    chk("after_flush_stall_cycles", 64'(sn), 64'(STUB_LAT + 4));

    // Flush coincident with ready
    we0 = we_cnt;
    ex_div_signed = 1'b0; ex_op_a = 32'd50; ex_op_b = 32'd5; ex_div_valid = 1'b1;
    step();
    wait_ready(got);
    chk("coinc_ready_seen", 64'(got), 64'd1);
    flush = 1'b1;
    step();
    flush = 1'b0; ex_div_valid = 1'b0;
    #1;
    chk("coinc_annul", 64'(dv.div_annul_o), 64'd1);
    repeat (2) step();
    chk("coinc_no_we", 64'(we_cnt - we0), 64'd0);

    // Flush in DONE
    we0 = we_cnt;
    ex_div_signed = 1'b0; ex_op_a = 32'd60; ex_op_b = 32'd6; ex_div_valid = 1'b1;
    step();
    wait_ready(got);
    step();
    flush = 1'b1;
    #1;
    chk("done_flush_we", 64'(hilo_we), 64'd0);
    chk("done_flush_stall", 64'(stall_o), 64'd0);
    step();
    flush = 1'b0; ex_div_valid = 1'b0;
    step();
    chk("done_flush_we_count", 64'(we_cnt - we0), 64'd0);

    // Watchdog with a divider that never answers
    stub_never = 1'b1; to0 = to_cnt; we0 = we_cnt;
    ex_div_signed = 1'b1; ex_op_a = 32'd77; ex_op_b = 32'd7; ex_div_valid = 1'b1;
    sn = 0; got = 1'b0;
    for (int i = 0; i < 120 && !got; i++) begin
      #1;
      if (timeout_o === 1'b1) got = 1'b1;
      else begin
        if (stall_o === 1'b1) sn++;
        @(posedge clk);
      end
    end
    chk("timeout_seen", 64'(got), 64'd1);
    chk("timeout_cycle", 64'(sn), 64'(TIMEOUT + 1));
    chk("timeout_annul", {dv.div_annul_o, dv.div_start_o}, 64'd2);
    ex_div_valid = 1'b0; stub_never = 1'b0;
    repeat (2) step();
    chk("timeout_pulse_count", 64'(to_cnt - to0), 64'd1);
    chk("timeout_no_we", 64'(we_cnt - we0), 64'd0);
    run_div(1'b0, 32'd81, 32'd9, sn, hw, lw, sw, got);
    chk("timeout_recover", {hw, lw}, {32'd0, 32'd9});

    // Randomized divides, back-to-back
    for (int k = 0; k < 10; k++) begin
      rs = 1'($urandom % 2);
      ra = $urandom;
      case ($urandom % 4)
        0: rb = 32'd0;
        1: rb = $urandom % 16;
        default: rb = $urandom;
      endcase
      exp_r = ref_div(rs, ra, rb);
      we0 = we_cnt;
      run_div(rs, ra, rb, sn, hw, lw, sw, got);
      chk("rand_hilo", {hw, lw}, exp_r);
      chk("rand_we_count", 64'(we_cnt - we0), 64'd1);
      chk("rand_stall_cycles", 64'(sn), 64'((rb == 32'd0) ? ZERO_LAT + 4 : STUB_LAT + 4));
    end

    // Reset in the middle of BUSY
    ex_div_signed = 1'b1; ex_op_a = 32'd12345; ex_op_b = 32'd11; ex_div_valid = 1'b1;
    repeat (6) step();
    rst = 1'b1; ex_div_valid = 1'b0;
    step();
    rst = 1'b0;
    #1;
    chk("midrst_ctrl", {59'd0, dv.div_start_o, dv.div_annul_o, dv.div_signed_o, hilo_we, timeout_o}, 64'd0);
    chk("midrst_ops", {dv.div_op1_o, dv.div_op2_o}, 64'd0);
    chk("midrst_hilo", {hi_o, lo_o}, 64'd0);
    chk("midrst_stall", 64'(stall_o), 64'd0);
    step();

    chk("annul_start_overlap", 64'(overlap_cnt), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
